cnn_frame_sequencer: RTL and testbench

Synthesizable front-end that feeds `cnn_top` a stream of images and returns one classification per image. Pixels arrive on a valid/ready stream and are assembled into the flattened image bus. The block then pulses the core's start, waits for `done` under a watchdog, and presents the predicted class on a result valid/ready port. It supports back-to-back frames, parametrised image geometry and pixel/class widths, frame-length error detection, and a timeout.

---
 rtl/cnn_frame_sequencer.sv | 105 ++++++++++
 tb/tb_cnn_frame_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: assembles a pixel stream into a flattened image, runs cnn_top once per frame and returns the class.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   s_pix_valid/ready/data/last  raster-order pixel stream, last marks the final pixel of a frame
//   cnn_image                    flattened image, pixel i at bits [i*PIX_W +: PIX_W]
//   cnn_start                    one-cycle start pulse to the core
//   cnn_done, cnn_class          core completion level and prediction
//   m_res_valid/ready            result handshake
//   m_res_class/frame/err        prediction, frame sequence number, {timeout, frame length error}
module cnn_frame_sequencer #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int PIX_W   = 8,
    parameter int CLASS_W = 4,
    parameter int FRAME_W = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_pix_valid,
    output logic                           s_pix_ready,
    input  logic [PIX_W-1:0]               s_pix_data,
    input  logic                           s_pix_last,
    output logic [IMG_W*IMG_H*PIX_W-1:0]   cnn_image,
    output logic                           cnn_start,
    input  logic                           cnn_done,
    input  logic [CLASS_W-1:0]             cnn_class,
    output logic                           m_res_valid,
    input  logic                           m_res_ready,
    output logic [CLASS_W-1:0]             m_res_class,
    output logic [FRAME_W-1:0]             m_res_frame,
    output logic [1:0]                     m_res_err
);
    localparam int N  = IMG_W * IMG_H;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [2:0] LOAD   = 3'd0;
    localparam logic [2:0] DRAIN  = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] RESULT = 3'd4;
    logic [2:0]         state;
    logic [IW-1:0]      idx;
    logic [CW-1:0]      cnt;
    logic [N*PIX_W-1:0] img;
    logic [1:0]         err;
    logic               pix_hs, at_end, tmo;
    // Gated by rst_n so the stream sees not-ready while reset is held, even though reset parks in LOAD.
    assign s_pix_ready = rst_n && (state == LOAD || state == DRAIN);
    assign pix_hs      = s_pix_valid && s_pix_ready;
    assign at_end      = idx == IW'(N - 1);
    assign tmo         = cnt == CW'(TIMEOUT - 1);
    assign cnn_start   = state == START;
    assign m_res_valid = state == RESULT;
    assign m_res_err   = err;
    assign cnn_image   = img;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            idx         <= '0;
            cnt         <= '0;
            img         <= '0;
            err         <= '0;
            m_res_class <= '0;
            m_res_frame <= '0;
        end else begin
            case (state)
                LOAD: if (pix_hs) begin
                    img[idx*PIX_W +: PIX_W] <= s_pix_data;
                    idx <= idx + IW'(1);
                    // A short frame leaves the unwritten slots zero; a long one discards the excess in DRAIN.
                    if (s_pix_last || at_end) begin
                        err[0] <= !(s_pix_last && at_end);
                        state  <= s_pix_last ? START : DRAIN;
                    end
                end
                DRAIN: state <= (pix_hs && s_pix_last) ? START : DRAIN;
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    // done takes priority over an expiring watchdog in the same cycle
                    if (cnn_done) begin
                        m_res_class <= cnn_class;
                        state       <= RESULT;
                    end else if (tmo) begin
                        err[1]      <= 1'b1;
                        m_res_class <= '1;
                        state       <= RESULT;
                    end
                end
                RESULT: if (m_res_ready) begin
                    m_res_frame <= m_res_frame + FRAME_W'(1);
                    img         <= '0;
                    err         <= '0;
                    idx         <= '0;
                    state       <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer: drives a default-geometry and a 4x4 sequencer against behavioural core models and a result scoreboard.
module tb_cnn_frame_sequencer;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic          b_valid, b_ready, b_last, b_start, b_done, b_rvalid, b_rrdy;
    logic [7:0]    b_data, b_rfrm;
    logic [6271:0] b_img;
    logic [3:0]    b_ccls, b_rcls;
    logic [1:0]    b_rerr;
    logic          s_valid, s_ready, s_last, s_start, s_done, s_rvalid, s_rrdy;
    logic [7:0]    s_data;
    logic [127:0]  s_img;
    logic [3:0]    s_ccls, s_rcls;
    logic [1:0]    s_rfrm, s_rerr;

    logic [6271:0] b_img_q[$];
    logic [3:0]    b_cq[$];
    int            b_dq[$];
    logic [13:0]   b_exp_q[$];
    logic [7:0]    b_fr = 0;
    int            b_starts = 0;
    logic [127:0]  s_img_q[$];
    logic [3:0]    s_cq[$];
    int            s_dq[$];
    logic [13:0]   s_exp_q[$];
    logic [1:0]    s_fr = 0;
    int            s_starts = 0;

    cnn_frame_sequencer u_big (
        .clk(clk), .rst_n(rst_n),
        .s_pix_valid(b_valid), .s_pix_ready(b_ready), .s_pix_data(b_data), .s_pix_last(b_last),
        .cnn_image(b_img), .cnn_start(b_start), .cnn_done(b_done), .cnn_class(b_ccls),
        .m_res_valid(b_rvalid), .m_res_ready(b_rrdy), .m_res_class(b_rcls),
        .m_res_frame(b_rfrm), .m_res_err(b_rerr)
    );

    cnn_frame_sequencer #(.IMG_W(4), .IMG_H(4), .FRAME_W(2), .TIMEOUT(16)) u_small (
        .clk(clk), .rst_n(rst_n),
        .s_pix_valid(s_valid), .s_pix_ready(s_ready), .s_pix_data(s_data), .s_pix_last(s_last),
        .cnn_image(s_img), .cnn_start(s_start), .cnn_done(s_done), .cnn_class(s_ccls),
        .m_res_valid(s_rvalid), .m_res_ready(s_rrdy), .m_res_class(s_rcls),
        .m_res_frame(s_rfrm), .m_res_err(s_rerr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic b_send(input int n, input int last_at, input int base, input logic [3:0] cls, input int dly, input bit push);
        logic [6271:0] im;
        int t;
        im = '0;
        if (push) begin
            for (int i = 0; i < 784; i++) im[i*8 +: 8] = 8'(i + base);
            b_img_q.push_back(im);
            b_cq.push_back(cls);
            b_dq.push_back(dly);
            b_exp_q.push_back({cls, b_fr, 2'b00});
            b_fr++;
        end
        for (int i = 0; i < n; i++) begin
            b_valid = 1;
            b_data  = 8'(i + base);
            b_last  = (i == last_at);
            t = 0;
            @(negedge clk);
            while (!b_ready && t < 10000) begin
                @(negedge clk);
                t++;
            end
            chk("b_pix_ready", b_ready, 1);
            @(posedge clk);
            #1;
        end
        b_valid = 0;
        b_last  = 0;
    endtask

    task automatic s_send(input int n, input int last_at, input int base, input logic [3:0] cls, input int dly);
        logic [127:0] im;
        int t;
        im = '0;
        for (int i = 0; i < 16; i++) if (i < n && i <= last_at) im[i*8 +: 8] = 8'(i + base);
        s_img_q.push_back(im);
        s_cq.push_back(cls);
        s_dq.push_back(dly);
        if (dly != -2) begin
            s_exp_q.push_back({(dly == -1) ? 4'hF : cls, 6'b0, s_fr, dly == -1, last_at != 15});
            s_fr++;
        end
        for (int i = 0; i < n; i++) begin
            s_valid = 1;
            s_data  = 8'(i + base);
            s_last  = (i == last_at);
            t = 0;
            @(negedge clk);
            while (!s_ready && t < 1000) begin
                @(negedge clk);
                t++;
            end
            chk("s_pix_ready", s_ready, 1);
            @(posedge clk);
            #1;
        end
        s_valid = 0;
        s_last  = 0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((b_exp_q.size() != 0 || s_exp_q.size() != 0) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", b_exp_q.size() + s_exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Core model for the default-geometry DUT: done after the queued delay, then checks the D+1 result timing.
    initial begin
        logic [6271:0] im;
        logic [3:0] c;
        int d;
        b_done = 0;
        b_ccls = 0;
        forever begin
            @(negedge clk);
            if (b_start) begin
                b_starts++;
                im = b_img_q.size() ? b_img_q.pop_front() : '0;
                c  = b_cq.size() ? b_cq.pop_front() : 4'h0;
                d  = b_dq.size() ? b_dq.pop_front() : -2;
                chk("b_image", b_img === im, 1);
                if (d >= 0) begin
                    repeat (d) @(posedge clk);
                    #1;
                    b_done = 1;
                    b_ccls = c;
                    @(negedge clk);
                    chk("b_valid_before_done", b_rvalid, 0);
                    @(posedge clk);
                    #1;
                    b_done = 0;
                    b_ccls = 4'(c + 5);
                    @(negedge clk);
                    chk("b_valid_after_done", b_rvalid, 1);
                end
            end
        end
    end

    // Core model for the 4x4 DUT: -1 never answers and checks the watchdog timing, -2 never answers silently.
    initial begin
        logic [127:0] im;
        logic [3:0] c;
        int d;
        s_done = 0;
        s_ccls = 0;
        forever begin
            @(negedge clk);
            if (s_start) begin
                s_starts++;
                im = s_img_q.size() ? s_img_q.pop_front() : '0;
                c  = s_cq.size() ? s_cq.pop_front() : 4'h0;
                d  = s_dq.size() ? s_dq.pop_front() : -2;
                chk("s_image", s_img, im[63:0]);
                chk("s_image_hi", s_img[127:64], im[127:64]);
                if (d == -1) begin
                    repeat (16) @(negedge clk);
                    chk("s_valid_before_timeout", s_rvalid, 0);
                    @(negedge clk);
                    chk("s_valid_at_timeout", s_rvalid, 1);
                end else if (d >= 0) begin
                    repeat (d) @(posedge clk);
                    #1;
                    s_done = 1;
                    s_ccls = c;
                    @(negedge clk);
                    chk("s_valid_before_done", s_rvalid, 0);
                    @(posedge clk);
                    #1;
                    s_done = 0;
                    s_ccls = 4'(c + 5);
                    @(negedge clk);
                    chk("s_valid_after_done", s_rvalid, 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_rvalid && b_rrdy) begin
            if (b_exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL b_result unexpected class=%0h frame=%0d err=%0b", b_rcls, b_rfrm, b_rerr);
            end else chk("b_result", {b_rcls, b_rfrm, b_rerr}, b_exp_q.pop_front());
        end
        if (rst_n && s_rvalid && s_rrdy) begin
            if (s_exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL s_result unexpected class=%0h frame=%0d err=%0b", s_rcls, s_rfrm, s_rerr);
            end else chk("s_result", {s_rcls, 6'b0, s_rfrm, s_rerr}, s_exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        b_valid = 0; b_last = 0; b_data = 0; b_rrdy = 1;
        s_valid = 0; s_last = 0; s_data = 0; s_rrdy = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_b_valid", b_rvalid, 0);
        chk("rst_b_start", b_start, 0);
        chk("rst_b_fields", {b_rcls, b_rfrm, b_rerr}, 0);
        chk("rst_b_image", b_img == '0, 1);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_s_image", s_img, 0);
        @(posedge clk);
        #1;
        // Full default frame, class 7 after 50 cycles.
        b_send(784, 783, 0, 4'd7, 50, 1);
        wait_drain();
        chk("b_start_count1", b_starts, 1);
        // Short, long, timeout and done-on-final-cycle frames on the 4x4 instance.
        s_send(10, 9, 16, 4'd2, 5);
        s_send(20, 19, 32, 4'd4, 3);
        s_send(16, 15, 48, 4'd0, -1);
        s_send(16, 15, 64, 4'd6, 16);
        wait_drain();
        chk("s_start_count1", s_starts, 4);
        // Fifth frame wraps the 2-bit frame counter and is held unaccepted for 10 cycles.
        s_rrdy = 0;
        s_send(16, 15, 80, 4'd9, 4);
        t = 0;
        while (!s_rvalid && t < 100) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", s_rvalid, 1);
            chk("hold_fields", {s_rcls, s_rfrm, s_rerr}, {4'd9, 2'd0, 2'b00});
            chk("hold_ready", s_ready, 0);
        end
        @(posedge clk);
        #1 s_rrdy = 1;
        wait_drain();
        // Reset while the 4x4 instance waits for a core that never answers.
        s_send(16, 15, 96, 4'd1, -2);
        repeat (5) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("rstw_s_outputs", {s_ready, s_start, s_rvalid, s_rcls, s_rfrm, s_rerr}, 0);
        chk("rstw_s_image", s_img, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        s_fr = 0;
        // Reset after 301 pixels of an unfinished default frame.
        b_send(301, -1, 0, 4'd0, 0, 0);
        rst_n = 0;
        #1;
        chk("rstl_b_outputs", {b_ready, b_start, b_rvalid, b_rcls, b_rfrm, b_rerr}, 0);
        chk("rstl_b_image", b_img == '0, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        b_fr = 0;
        // Fresh frames after reset start at frame 0; three default frames run back to back.
        s_send(16, 15, 7, 4'd5, 8);
        b_send(784, 783, 1, 4'd3, 20, 1);
        b_send(784, 783, 2, 4'd1, 5, 1);
        b_send(784, 783, 3, 4'd9, 30, 1);
        wait_drain();
        chk("b_start_count2", b_starts, 4);
        chk("s_start_count2", s_starts, 7);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
